axiwr_wr_arbiter: RTL
=====================

# axiwr_wr_arbiter

Two-to-one AXI4 write-channel arbiter that shares the single AXI-MM write slave port of the AXI-write-to-AXIS bridge between two write masters, e.g. two DMA engines feeding the same reconfigurable-module stream. A grant covers one full AW → W → B transaction and is handed out round-robin. Write address, data and response channels pass through combinationally under the current grant. The block also checks each burst's WLAST against AWLEN and reports a sticky error.

## Interface
Parameters:
- DATA_WIDTH, 128, W data width; WSTRB width is DATA_WIDTH/8.
- USER_WIDTH, 32, AWUSER width. The bridge takes AWUSER as the total transfer length in beats.

Ports (clock and reset first):
- clk  in  1  single clock for all logic.
- resetn  in  1  asynchronous, active-low reset.
- mN_awvalid / mN_awready  in / out  1  AW handshake of master N (N = 0, 1).
- mN_awaddr  in  64; mN_awlen  in  8; mN_awsize  in  3; mN_awburst  in  2; mN_awuser  in  USER_WIDTH  AW payload of master N.
- mN_wvalid / mN_wready  in / out  1; mN_wdata  in  DATA_WIDTH; mN_wstrb  in  DATA_WIDTH/8; mN_wlast  in  1  W channel of master N.
- mN_bvalid / mN_bready  out / in  1; mN_bresp  out  2  B channel of master N.
- s_awvalid / s_awready  out / in  1; s_awaddr, s_awlen, s_awsize, s_awburst, s_awuser  out  widths as above  AW channel to the bridge.
- s_wvalid / s_wready  out / in  1; s_wdata, s_wstrb, s_wlast  out  W channel to the bridge.
- s_bvalid / s_bready  in / out  1; s_bresp  in  2  B channel from the bridge.
- grant_id  out  1  index of the current or most recent granted master.
- busy  out  1  high in every state except IDLE.
- wlast_err  out  1  sticky protocol-error flag.
- err_clr  in  1  synchronous clear for wlast_err.

## Operation
- **States:** IDLE, AW, W, B, held in a 2-bit register.
- **IDLE:** if any mN_awvalid is high, pick a master and go to AW, registering grant_id.
  - Priority goes to the master other than last_grant; otherwise the single requester wins.
  - In IDLE all ready and valid outputs are 0.
- **AW:**
  - s_awvalid = m[g]_awvalid; m[g]_awready = s_awready.
  - AW payload is muxed from master g.
  - On handshake: latch awlen into len_q, clear beat_cnt, go to W.
- **W:**
  - s_wvalid = m[g]_wvalid; m[g]_wready = s_wready; W payload is muxed from master g.
  - On each handshake beat_cnt increments (8-bit).
  - On a handshake with wlast = 1, go to B.
- **B:**
  - s_bready = m[g]_bready; m[g]_bvalid = s_bvalid; m[g]_bresp = s_bresp.
  - On handshake: last_grant <= g, go to IDLE.
- **Non-granted master:** awready, wready and bvalid are all 0; its bresp output is 2'b00.
- **wlast_err** is set on either of these W handshakes:
  - wlast = 1 with beat_cnt != len_q;
  - beat_cnt == len_q with wlast = 0.
- **wlast_err behaviour:**
  - The state machine still follows WLAST as forwarded; the burst is never truncated or extended.
  - err_clr clears the flag; if a set and a clear occur in the same cycle, set wins.
- **Outputs with no active grant** (s_* payloads): drive 0 in IDLE; otherwise follow the muxed master.

## Timing
- **Reset (asynchronous, resetn low):**
  - State = IDLE, last_grant = 1 (so master 0 wins the first tie), grant_id = 0.
  - len_q = 0, beat_cnt = 0.
  - busy, wlast_err and all valid/ready outputs = 0.
- **Reset deasserting mid-transaction:** returns to IDLE with nothing issued. Upstream masters and the bridge are reset in the same domain.
- **Latency:**
  - Arbitration costs 1 cycle: AWVALID seen in IDLE, AW pass-through starts the next cycle.
  - All handshakes in AW, W and B are combinational pass-throughs with 0 added latency.
  - Minimum transaction occupancy is 1 + 1 + (awlen+1) + 1 cycles.
- **Simultaneous requests in IDLE:** round-robin, so a master cannot win twice in a row while the other is requesting.
- **Late requests:** a request arriving during AW, W or B is ignored until the next IDLE.
- **Valid before AW handshake:** W beats presented by the granted master before its AW handshake are held off (wready = 0 in AW).
- **W stalls:** W-channel bubbles (wvalid low) are passed through; beat_cnt counts only handshakes.
- **beat_cnt at awlen = 255:** counts 0..255 without needing a wrap; a missing WLAST sets wlast_err on beat 255, and beat_cnt then wraps to 0.

## Test plan
- **Single master:** m0 only, awlen = 3, s_awready, s_wready and bready all held 1 → AW passes at cycle 1, 4 W beats at cycles 2-5, B at cycle 6, busy low at cycle 7, wlast_err = 0.
- **Tie after reset:** m0 and m1 request simultaneously, awlen = 0 → m0 is granted first, then m1; grant_id sequence 0, 1; m1 sees no ready while m0 is granted.
- **Continuous requests:** both masters request back-to-back for 4 transactions → grants alternate 0, 1, 0, 1; m1_awaddr = 0x1000 appears on s_awaddr only while grant_id = 1.
- **Backpressure:** s_wready toggles 1, 0, 1, 0 with awlen = 7 → exactly 8 beats forwarded in order; beat_cnt reaches 7 when WLAST is accepted.
- **Protocol errors:**
  - WLAST asserted on beat 2 with awlen = 3 → wlast_err = 1, state goes to B, and the flag stays set through the next clean transaction.
  - err_clr pulse → flag returns to 0.
- **Reset mid-burst:** resetn pulled low during W beat 5 of an awlen = 15 burst → all ready/valid outputs are 0 immediately; after release state is IDLE and the first tie is granted to m0.

Source files
------------

// File: rtl/axiwr_wr_arbiter.sv
// Two-to-one AXI4 write-channel arbiter. One grant covers a full AW -> W -> B
// transaction, handed out round-robin. All channels pass through combinationally
// under the grant; WLAST/AWLEN disagreement raises a sticky error flag.
module axiwr_wr_arbiter #(
   parameter int unsigned DATA_WIDTH = 128,
   parameter int unsigned USER_WIDTH = 32
) (
   input  logic                    clk,
   input  logic                    resetn,
   // Master 0
   input  logic                    m0_awvalid,
   output logic                    m0_awready,
   input  logic [63:0]             m0_awaddr,
   input  logic [7:0]              m0_awlen,
   input  logic [2:0]              m0_awsize,
   input  logic [1:0]              m0_awburst,
   input  logic [USER_WIDTH-1:0]   m0_awuser,
   input  logic                    m0_wvalid,
   output logic                    m0_wready,
   input  logic [DATA_WIDTH-1:0]   m0_wdata,
   input  logic [DATA_WIDTH/8-1:0] m0_wstrb,
   input  logic                    m0_wlast,
   output logic                    m0_bvalid,
   input  logic                    m0_bready,
   output logic [1:0]              m0_bresp,
   // Master 1
   input  logic                    m1_awvalid,
   output logic                    m1_awready,
   input  logic [63:0]             m1_awaddr,
   input  logic [7:0]              m1_awlen,
   input  logic [2:0]              m1_awsize,
   input  logic [1:0]              m1_awburst,
   input  logic [USER_WIDTH-1:0]   m1_awuser,
   input  logic                    m1_wvalid,
   output logic                    m1_wready,
   input  logic [DATA_WIDTH-1:0]   m1_wdata,
   input  logic [DATA_WIDTH/8-1:0] m1_wstrb,
   input  logic                    m1_wlast,
   output logic                    m1_bvalid,
   input  logic                    m1_bready,
   output logic [1:0]              m1_bresp,
   // Shared slave port towards the bridge
   output logic                    s_awvalid,
   input  logic                    s_awready,
   output logic [63:0]             s_awaddr,
   output logic [7:0]              s_awlen,
   output logic [2:0]              s_awsize,
   output logic [1:0]              s_awburst,
   output logic [USER_WIDTH-1:0]   s_awuser,
   output logic                    s_wvalid,
   input  logic                    s_wready,
   output logic [DATA_WIDTH-1:0]   s_wdata,
   output logic [DATA_WIDTH/8-1:0] s_wstrb,
   output logic                    s_wlast,
   input  logic                    s_bvalid,
   output logic                    s_bready,
   input  logic [1:0]              s_bresp,
   // Status
   output logic                    grant_id,
   output logic                    busy,
   output logic                    wlast_err,
   input  logic                    err_clr
);

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StAw   = 2'd1,
      StW    = 2'd2,
      StB    = 2'd3
   } state_e;

   state_e     state_q, state_d;
   logic       grant_q, grant_d;
   logic       last_grant_q, last_grant_d;
   logic [7:0] len_q, len_d;
   logic [7:0] beat_cnt_q, beat_cnt_d;
   logic       wlast_err_q, wlast_err_d;

   // Signals of the currently granted master
   logic                    g_awvalid;
   logic [63:0]             g_awaddr;
   logic [7:0]              g_awlen;
   logic [2:0]              g_awsize;
   logic [1:0]              g_awburst;
   logic [USER_WIDTH-1:0]   g_awuser;
   logic                    g_wvalid;
   logic [DATA_WIDTH-1:0]   g_wdata;
   logic [DATA_WIDTH/8-1:0] g_wstrb;
   logic                    g_wlast;
   logic                    g_bready;

   logic aw_hs, w_hs, b_hs;

   // Select the granted master's upstream signals
   always_comb begin
      if (grant_q) begin
         g_awvalid = m1_awvalid;
         g_awaddr  = m1_awaddr;
         g_awlen   = m1_awlen;
         g_awsize  = m1_awsize;
         g_awburst = m1_awburst;
         g_awuser  = m1_awuser;
         g_wvalid  = m1_wvalid;
         g_wdata   = m1_wdata;
         g_wstrb   = m1_wstrb;
         g_wlast   = m1_wlast;
         g_bready  = m1_bready;
      end else begin
         g_awvalid = m0_awvalid;
         g_awaddr  = m0_awaddr;
         g_awlen   = m0_awlen;
         g_awsize  = m0_awsize;
         g_awburst = m0_awburst;
         g_awuser  = m0_awuser;
         g_wvalid  = m0_wvalid;
         g_wdata   = m0_wdata;
         g_wstrb   = m0_wstrb;
         g_wlast   = m0_wlast;
         g_bready  = m0_bready;
      end
   end

   assign aw_hs = (state_q == StAw) && g_awvalid && s_awready;
   assign w_hs  = (state_q == StW)  && g_wvalid  && s_wready;
   assign b_hs  = (state_q == StB)  && s_bvalid  && g_bready;

   // Next-state: arbitration, burst tracking and sticky error flag
   always_comb begin
      state_d      = state_q;
      grant_d      = grant_q;
      last_grant_d = last_grant_q;
      len_d        = len_q;
      beat_cnt_d   = beat_cnt_q;
      wlast_err_d  = wlast_err_q;
      unique case (state_q)
         StIdle: begin
            if (m0_awvalid || m1_awvalid) begin
               // On a tie the master that did not win last time goes first
               if (m0_awvalid && m1_awvalid) grant_d = ~last_grant_q;
               else                          grant_d = m1_awvalid;
               state_d = StAw;
            end
         end
         StAw: begin
            if (aw_hs) begin
               len_d      = g_awlen;
               beat_cnt_d = 8'd0;
               state_d    = StW;
            end
         end
         StW: begin
            if (w_hs) begin
               beat_cnt_d = beat_cnt_q + 8'd1;
               // WLAST alone ends the burst, even when it disagrees with AWLEN
               if (g_wlast) state_d = StB;
            end
         end
         StB: begin
            if (b_hs) begin
               last_grant_d = grant_q;
               state_d      = StIdle;
            end
         end
      endcase
      if (err_clr) wlast_err_d = 1'b0;
      // Setting after clearing gives a same-cycle set priority
      if (w_hs && (g_wlast != (beat_cnt_q == len_q))) wlast_err_d = 1'b1;
   end

   // State and tracking registers
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q      <= StIdle;
         grant_q      <= 1'b0;
         last_grant_q <= 1'b1;
         len_q        <= 8'd0;
         beat_cnt_q   <= 8'd0;
         wlast_err_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         grant_q      <= grant_d;
         last_grant_q <= last_grant_d;
         len_q        <= len_d;
         beat_cnt_q   <= beat_cnt_d;
         wlast_err_q  <= wlast_err_d;
      end
   end

   // Channel pass-through gated by state and grant
   always_comb begin
      s_awvalid  = 1'b0;
      s_awaddr   = '0;
      s_awlen    = '0;
      s_awsize   = '0;
      s_awburst  = '0;
      s_awuser   = '0;
      s_wvalid   = 1'b0;
      s_wdata    = '0;
      s_wstrb    = '0;
      s_wlast    = 1'b0;
      s_bready   = 1'b0;
      m0_awready = 1'b0;
      m0_wready  = 1'b0;
      m0_bvalid  = 1'b0;
      m0_bresp   = 2'b00;
      m1_awready = 1'b0;
      m1_wready  = 1'b0;
      m1_bvalid  = 1'b0;
      m1_bresp   = 2'b00;
      if (state_q != StIdle) begin
         s_awaddr  = g_awaddr;
         s_awlen   = g_awlen;
         s_awsize  = g_awsize;
         s_awburst = g_awburst;
         s_awuser  = g_awuser;
         s_wdata   = g_wdata;
         s_wstrb   = g_wstrb;
         s_wlast   = g_wlast;
      end
      unique case (state_q)
         StIdle: ;
         StAw: begin
            s_awvalid = g_awvalid;
            if (grant_q) m1_awready = s_awready;
            else         m0_awready = s_awready;
         end
         StW: begin
            s_wvalid = g_wvalid;
            if (grant_q) m1_wready = s_wready;
            else         m0_wready = s_wready;
         end
         StB: begin
            s_bready = g_bready;
            if (grant_q) begin
               m1_bvalid = s_bvalid;
               m1_bresp  = s_bresp;
            end else begin
               m0_bvalid = s_bvalid;
               m0_bresp  = s_bresp;
            end
         end
      endcase
   end

   assign grant_id  = grant_q;
   assign busy      = (state_q != StIdle);
   assign wlast_err = wlast_err_q;

endmodule
